sum_accumulator: RTL and testbench

Downstream consumer of the 4-bit adder stage. Treats each adder result {Overflow, Sum} as an unsigned (IN_W+1)-bit value and accumulates FRAME_LEN accepted samples into a saturating ACC_W-bit total. It then presents the frame total on a valid/ready output port. Sits between the adder and any result sink (display, logger or next datapath stage).

---
 rtl/sum_acc_pkg.sv | 23 ++
 rtl/sum_acc_sat_add.sv | 17 +
 rtl/sum_accumulator.sv | 121 ++++++++++++
 tb/tb_sum_accumulator.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sum_acc_pkg.sv
// Shared types and default sizing for the adder-result accumulator.
// The top module derives its own limits from its parameters; these are the defaults.
package sum_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int IN_W_DEF      = 4;
    localparam int ACC_W_DEF     = 8;
    localparam int FRAME_LEN_DEF = 8;
    localparam int CNT_W_DEF     = 4;

    localparam int ACC_MAX = 2**ACC_W_DEF - 1;
    localparam int SMP_W   = IN_W_DEF + 1;

    // An adder result carries its carry-out as the extra top bit.
    function automatic int smp_width(input int in_w);
        return in_w + 1;
    endfunction

endpackage

// File: rtl/sum_acc_sat_add.sv
// Combinational W-bit saturating adder; sat_o flags that the true sum exceeded 2**W-1.
module sat_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         sat_o
);

    logic [W:0] raw;

    assign raw   = {1'b0, a_i} + {1'b0, b_i};
    assign sat_o = raw[W];
    assign sum_o = raw[W] ? {W{1'b1}} : raw[W-1:0];

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates FRAME_LEN adder results into a saturating total and hands the
// frame total to a sink over a valid/ready port.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int IN_W      = IN_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             InValid,
    output logic             InReady,
    input  logic [IN_W-1:0]  Sum,
    input  logic             Overflow,
    input  logic             Clear,
    output logic [ACC_W-1:0] AccOut,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             SatFlag
);

    localparam int SW = smp_width(IN_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [ACC_W-1:0] out_q, out_d;
    logic             oval_q, oval_d;
    logic             osat_q, osat_d;

    logic [SW-1:0]    sample;
    logic [ACC_W-1:0] sample_ext;
    logic [ACC_W-1:0] acc_sum;
    logic             add_sat;
    logic             accept;

    assign sample     = {Overflow, Sum};
    assign sample_ext = ACC_W'(sample);

    sat_add #(.W(ACC_W)) u_sat_add (
        .a_i   (acc_q),
        .b_i   (sample_ext),
        .sum_o (acc_sum),
        .sat_o (add_sat)
    );

    assign InReady = En && (state_q == ACCUM) && !Clear;
    assign accept  = InValid && InReady;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        out_d   = out_q;
        oval_d  = oval_q;
        osat_d  = osat_q;
        case (state_q)
            ACCUM: begin
                // Clear only acts when the block is enabled, so En low freezes everything.
                if (En && Clear) begin
                    acc_d = '0;
                    cnt_d = '0;
                    sat_d = 1'b0;
                end else if (accept) begin
                    if (cnt_q == LAST_CNT) begin
                        out_d   = acc_sum;
                        osat_d  = sat_q | add_sat;
                        oval_d  = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                        state_d = HOLD;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + 1'b1;
                        sat_d = sat_q | add_sat;
                    end
                end
            end
            HOLD: begin
                // Drain does not depend on En so a stalled pipe can still empty.
                if (oval_q && OutReady) begin
                    oval_d  = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            out_q   <= '0;
            oval_q  <= 1'b0;
            osat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            out_q   <= out_d;
            oval_q  <= oval_d;
            osat_q  <= osat_d;
        end
    end

    assign AccOut   = out_q;
    assign OutValid = oval_q;
    assign SatFlag  = osat_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed checks of sum_accumulator with hand-computed frame totals.
module tb_sum_accumulator;

    logic       Clk = 1'b0;
    logic       Reset, En, InValid, Overflow, Clear, OutReady;
    logic [3:0] Sum;

    logic       InReady, OutValid, SatFlag;
    logic [7:0] AccOut;
    logic       InReady10, OutValid10, SatFlag10;
    logic [7:0] AccOut10;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 Clk = ~Clk;

    sum_accumulator dut (
        .Clk(Clk), .Reset(Reset), .En(En), .InValid(InValid), .InReady(InReady),
        .Sum(Sum), .Overflow(Overflow), .Clear(Clear), .AccOut(AccOut),
        .OutValid(OutValid), .OutReady(OutReady), .SatFlag(SatFlag)
    );

    sum_accumulator #(.FRAME_LEN(10)) dut10 (
        .Clk(Clk), .Reset(Reset), .En(En), .InValid(InValid), .InReady(InReady10),
        .Sum(Sum), .Overflow(Overflow), .Clear(Clear), .AccOut(AccOut10),
        .OutValid(OutValid10), .OutReady(OutReady), .SatFlag(SatFlag10)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ov, input logic [3:0] s);
        InValid  = v;
        Overflow = ov;
        Sum      = s;
    endtask

    task automatic do_reset();
        #2 Reset = 1'b1;
        step(1);
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; En = 1'b1; Clear = 1'b0; OutReady = 1'b0;
        drive(1'b1, 1'b1, 4'd15);

        // 1: async reset mid-cycle with a valid sample presented
        #3 Reset = 1'b1;
        #1;
        chk("rst_accout", AccOut, 0);
        chk("rst_ovalid", OutValid, 0);
        chk("rst_sat", SatFlag, 0);
        chk("rst_inready", InReady, 1);
        step(2);
        drive(1'b0, 1'b0, 4'd0);
        Reset = 1'b0;
        step(1);
        chk("rst_hold_ovalid", OutValid, 0);

        // 2: eight accepts of 3
        drive(1'b1, 1'b0, 4'd3);
        step(7);
        chk("f24_not_yet", OutValid, 0);
        step(1);
        chk("f24_ovalid", OutValid, 1);
        chk("f24_accout", AccOut, 24);
        chk("f24_sat", SatFlag, 0);
        chk("f24_inready", InReady, 0);

        // 4: back-pressure in HOLD, then drain
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("hold_accout", AccOut, 24);
            chk("hold_ovalid", OutValid, 1);
        end
        OutReady = 1'b1;
        step(1);
        OutReady = 1'b0;
        drive(1'b0, 1'b0, 4'd0);
        chk("drain_ovalid", OutValid, 0);
        chk("drain_inready", InReady, 1);
        chk("drain_accout", AccOut, 24);

        // 5: three 5s, Clear with a valid sample, then eight 1s
        drive(1'b1, 1'b0, 4'd5);
        step(3);
        Clear = 1'b1;
        #1 chk("clr_inready", InReady, 0);
        step(1);
        Clear = 1'b0;
        drive(1'b1, 1'b0, 4'd1);
        step(7);
        chk("clr_not_yet", OutValid, 0);
        step(1);
        chk("clr_ovalid", OutValid, 1);
        chk("clr_accout", AccOut, 8);
        OutReady = 1'b1;
        step(1);
        OutReady = 1'b0;

        // 6: En low for four cycles mid-frame, value 2 held valid
        drive(1'b1, 1'b0, 4'd2);
        step(3);
        En = 1'b0;
        #1 chk("en_inready", InReady, 0);
        step(4);
        En = 1'b1;
        step(4);
        chk("en_not_yet", OutValid, 0);
        step(1);
        chk("en_ovalid", OutValid, 1);
        chk("en_accout", AccOut, 16);
        #2 Reset = 1'b1;
        #1;
        chk("hold_rst_ovalid", OutValid, 0);
        chk("hold_rst_accout", AccOut, 0);
        step(1);
        Reset = 1'b0;

        // 3: value 31 into FRAME_LEN=8 and FRAME_LEN=10
        do_reset();
        drive(1'b1, 1'b1, 4'd15);
        step(8);
        chk("f248_ovalid", OutValid, 1);
        chk("f248_accout", AccOut, 248);
        chk("f248_sat", SatFlag, 0);
        chk("f10_not_yet", OutValid10, 0);
        step(2);
        chk("f10_ovalid", OutValid10, 1);
        chk("f10_accout", AccOut10, 255);
        chk("f10_sat", SatFlag10, 1);
        chk("f248_still", AccOut, 248);
        drive(1'b0, 1'b0, 4'd0);
        step(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got %0d expected %0d", n_chk, 0);
        $fatal(1);
    end

endmodule
